// File: rtl/synapse_array_delay.sv
// -----------------------------------------------------------------------------
// synapse_array_delay
//
// Multi-channel synapse bank. Each channel delays presynaptic spikes by a
// programmable number of cycles in its own shift register, so every spike in
// flight is kept. Each delayed spike is scaled by a signed per-channel weight,
// and all channels are summed into one registered postsynaptic current word.
//
// Optional feature macro: SYN_DECAY_EN
//   undefined : psc_out is the weighted sum for each cycle
//   defined   : psc_out is a leaky, saturating trace of that sum
//
// Ports
//   clk         in   1         system clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   en          in   1         1 = advance delay lines, 0 = freeze (outputs 0)
//   spike_in    in   N_CH      presynaptic spike per channel
//   cfg_we      in   1         configuration write strobe
//   cfg_ch      in   CH_W      channel addressed by the write
//   cfg_delay   in   DLY_W     new delay (0 -> 1, above DEPTH -> DEPTH)
//   cfg_weight  in   WEIGHT_W  new signed weight
//   spike_out   out  N_CH      delayed spike per channel
//   psc_out     out  SUM_W     signed weighted sum / trace
//   psc_valid   out  1         psc_out is non-zero
// -----------------------------------------------------------------------------
module synapse_array_delay #(
   parameter int N_CH           = 4,
   parameter int DEPTH          = 8,
   parameter int WEIGHT_W       = 6,
   parameter int DEFAULT_DELAY  = 1,
   parameter int DEFAULT_WEIGHT = 1,
   parameter int DECAY_SHIFT    = 2,
   localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int DLY_W         = $clog2(DEPTH + 1),
   localparam int SUM_W         = WEIGHT_W + $clog2(N_CH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [N_CH-1:0]            spike_in,
   input  logic                       cfg_we,
   input  logic [CH_W-1:0]            cfg_ch,
   input  logic [DLY_W-1:0]           cfg_delay,
   input  logic signed [WEIGHT_W-1:0] cfg_weight,
   output logic [N_CH-1:0]            spike_out,
   output logic signed [SUM_W-1:0]    psc_out,
   output logic                       psc_valid
);

   // Elaboration-time sanity check of the parameter set.
   if (N_CH < 1 || DEPTH < 1 || DECAY_SHIFT < 0 ||
       DEFAULT_DELAY < 1 || DEFAULT_DELAY > DEPTH) begin : g_bad_param
      $error("synapse_array_delay: illegal parameter combination");
   end

   // One past the last valid channel, sized so the compare never truncates.
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(N_CH);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [DEPTH-1:0]           line_q   [N_CH];
   logic [DLY_W-1:0]           delay_q  [N_CH];
   logic signed [WEIGHT_W-1:0] weight_q [N_CH];
   logic [N_CH-1:0]            spike_q;
   logic signed [SUM_W-1:0]    psc_q;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic                    cfg_hit;
   logic [N_CH-1:0]         tap;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] psc_next;

   // Out-of-range delays are clamped rather than rejected.
   function automatic logic [DLY_W-1:0] eff_delay(input logic [DLY_W-1:0] d);
      if (d == '0)
         return DLY_W'(1);
      else if (d > DLY_W'(DEPTH))
         return DLY_W'(DEPTH);
      else
         return d;
   endfunction

   assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

   // Tap select: bit (d-1) of the line, so a spike entering bit0 at edge k is
   // registered onto spike_out at edge k+d.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         // NOTE: every combinational output gets a default before any
         // conditional assignment, otherwise the tool infers a latch.
         tap[c] = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (eff_delay(delay_q[c]) == DLY_W'(i + 1))
               tap[c] = line_q[c][i];
         end
      end
   end

   // Weighted sum of the spikes currently on spike_q; SUM_W leaves room for
   // all channels at full-scale weight, so no saturation is needed here.
   always_comb begin
      sum = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (spike_q[c])
            sum = sum + SUM_W'(weight_q[c]);
      end
   end

`ifdef SYN_DECAY_EN
   // Leaky trace: two guard bits absorb the worst-case excursion of
   // trace - leak + sum before saturation back to SUM_W.
   localparam int TR_W = SUM_W + 2;
   localparam logic signed [TR_W-1:0] SAT_MAX = {3'b000, {(SUM_W-1){1'b1}}};
   localparam logic signed [TR_W-1:0] SAT_MIN = {3'b111, {(SUM_W-1){1'b0}}};

   logic signed [TR_W-1:0] tr_ext;
   logic signed [TR_W-1:0] leak;
   logic signed [TR_W-1:0] tr_raw;

   always_comb begin
      tr_ext = TR_W'(psc_q);
      leak   = tr_ext >>> DECAY_SHIFT;
      // A small trace would otherwise stall; force one LSB step toward zero.
      if (leak == '0 && psc_q != '0)
         leak = psc_q[SUM_W-1] ? '1 : TR_W'(1);
      tr_raw = tr_ext - leak + TR_W'(sum);
      if (tr_raw > SAT_MAX)
         psc_next = SAT_MAX[SUM_W-1:0];
      else if (tr_raw < SAT_MIN)
         psc_next = SAT_MIN[SUM_W-1:0];
      else
         psc_next = tr_raw[SUM_W-1:0];
   end
`else
   assign psc_next = sum;
`endif

   // --------------------------------------------------------------------------
   // Sequential state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the per-channel line/config arrays are plain flops, not RAM,
         // so they are reset like any other register; reset must flush all
         // in-flight spikes and restore the default configuration.
         for (int c = 0; c < N_CH; c++) begin
            line_q[c]   <= '0;
            delay_q[c]  <= DLY_W'(DEFAULT_DELAY);
            weight_q[c] <= WEIGHT_W'(DEFAULT_WEIGHT);
         end
         spike_q <= '0;
         psc_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples the pre-edge values of its neighbours.
         for (int c = 0; c < N_CH; c++) begin
            if (cfg_hit && cfg_ch == CH_W'(c)) begin
               // Reconfiguration discards this channel's in-flight spikes;
               // a spike arriving on the same edge enters after the clear.
               delay_q[c]  <= cfg_delay;
               weight_q[c] <= cfg_weight;
               line_q[c]   <= en ? DEPTH'(spike_in[c]) : '0;
               spike_q[c]  <= 1'b0;
            end else if (en) begin
               line_q[c]  <= (line_q[c] << 1) | DEPTH'(spike_in[c]);
               spike_q[c] <= tap[c];
            end
         end
         if (en)
            psc_q <= psc_next;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: registered state, forced to zero while frozen. The registers
   // themselves hold, so resuming continues exactly where the freeze began.
   // --------------------------------------------------------------------------
   assign spike_out = en ? spike_q : '0;
   assign psc_out   = en ? psc_q : '0;
   assign psc_valid = (psc_out != '0);

endmodule

// File: tb/tb_synapse_array_delay.sv
// -----------------------------------------------------------------------------
// tb_synapse_array_delay
//
// Scoreboard bench for synapse_array_delay with default parameters. Each driven
// spike pushes its expected spike_out edge and psc_out contribution into a
// queue; after every clock edge the entries due on that edge are popped and the
// DUT outputs are compared (all other outputs expected zero).
// -----------------------------------------------------------------------------
module tb_synapse_array_delay;

   localparam int N_CH     = 4;
   localparam int DEPTH    = 8;
   localparam int WEIGHT_W = 6;
   localparam int CH_W     = 2;
   localparam int DLY_W    = 4;
   localparam int SUM_W    = 9;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       en;
   logic [N_CH-1:0]            spike_in;
   logic                       cfg_we;
   logic [CH_W-1:0]            cfg_ch;
   logic [DLY_W-1:0]           cfg_delay;
   logic signed [WEIGHT_W-1:0] cfg_weight;
   logic [N_CH-1:0]            spike_out;
   logic signed [SUM_W-1:0]    psc_out;
   logic                       psc_valid;

   synapse_array_delay dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .spike_in   (spike_in),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_delay  (cfg_delay),
      .cfg_weight (cfg_weight),
      .spike_out  (spike_out),
      .psc_out    (psc_out),
      .psc_valid  (psc_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int edge_no;
      int ch;      // -1 marks a psc contribution
      int psc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   dly [N_CH];
   int   wgt [N_CH];

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff(input int d);
      if (d == 0) return 1;
      if (d > DEPTH) return DEPTH;
      return d;
   endfunction

   // One clock edge, then compare outputs against everything due on it.
   task automatic step();
      logic [N_CH-1:0] em;
      int              ep;
      @(posedge clk);
      cyc++;
      #1;
      em = '0;
      ep = 0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].edge_no == cyc) begin
            if (sb[i].ch >= 0) em[sb[i].ch] = 1'b1;
            else               ep += sb[i].psc;
            sb.delete(i);
         end
      end
      check("spike_out", spike_out, em);
      check("psc_out", $signed(psc_out), ep);
      check("psc_valid", psc_valid, (ep != 0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_spike(input int ch, input int edge_out, input int w);
      exp_t e;
      e.edge_no = edge_out;     e.ch = ch; e.psc = 0; sb.push_back(e);
      e.edge_no = edge_out + 1; e.ch = -1; e.psc = w; sb.push_back(e);
   endtask

   task automatic send(input logic [N_CH-1:0] mask);
      for (int c = 0; c < N_CH; c++)
         if (mask[c]) push_spike(c, cyc + 1 + eff(dly[c]), wgt[c]);
      spike_in = mask;
      step();
      spike_in = '0;
   endtask

   task automatic cfg(input int ch, input int d, input int w);
      cfg_we     = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_delay  = DLY_W'(d);
      cfg_weight = WEIGHT_W'(w);
      dly[ch]    = d;
      wgt[ch]    = w;
      step();
      cfg_we     = 1'b0;
   endtask

   initial begin
      int e0;
      rst_n      = 1'b0;
      en         = 1'b1;
      spike_in   = '0;
      cfg_we     = 1'b0;
      cfg_ch     = '0;
      cfg_delay  = '0;
      cfg_weight = '0;
      for (int c = 0; c < N_CH; c++) begin dly[c] = 1; wgt[c] = 1; end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_spike_out", spike_out, 0);
      check("rst_psc_out", $signed(psc_out), 0);
      check("rst_psc_valid", psc_valid, 0);
      rst_n = 1'b1;
      idle(2);

      // Defaults: delay 1, weight +1
      send(4'b0001);
      idle(3);

      // ch1 delay 4 weight +5, three consecutive spikes
      cfg(1, 4, 5);
      send(4'b0010);
      send(4'b0010);
      send(4'b0010);
      idle(6);

      // Coincident +5 and -3 at equal delays -> +2
      cfg(0, 2, 5);
      cfg(2, 2, -3);
      send(4'b0101);
      idle(4);

      // ch3 delay 6: in-flight spike discarded by a rewrite; a spike on the
      // write edge emerges after the new delay of 2
      cfg(3, 6, 1);
      spike_in = 4'b1000;
      step();
      spike_in = '0;
      step();
      cfg_we     = 1'b1;
      cfg_ch     = 2'd3;
      cfg_delay  = 4'd2;
      cfg_weight = 6'sd1;
      spike_in   = 4'b1000;
      dly[3] = 2;
      wgt[3] = 1;
      push_spike(3, cyc + 1 + 2, 1);
      step();
      cfg_we   = 1'b0;
      spike_in = '0;
      idle(8);

      // Freeze: ch0 delay 3 spike stretched by 3 frozen edges; spikes during
      // freeze ignored; a write during freeze still clears ch1's spike
      cfg(0, 3, 2);
      idle(2);
      e0 = cyc + 1;
      push_spike(0, e0 + 6, 2);
      spike_in = 4'b0011;
      step();
      spike_in = '0;
      step();
      en       = 1'b0;
      spike_in = 4'b1111;
      step();
      cfg_we     = 1'b1;
      cfg_ch     = 2'd1;
      cfg_delay  = 4'd4;
      cfg_weight = 6'sd5;
      step();
      cfg_we = 1'b0;
      step();
      en       = 1'b1;
      spike_in = '0;
      idle(6);

      // Delay clamp: 0 acts as 1, 12 acts as DEPTH; back-to-back spikes kept
      cfg(2, 0, 1);
      send(4'b0100);
      idle(3);
      cfg(2, 12, -2);
      send(4'b0100);
      send(4'b0100);
      step();
      send(4'b0100);
      idle(11);

      // A write to ch2 leaves spikes in flight on ch0/ch1 alone
      send(4'b0011);
      cfg(2, 12, -2);
      idle(6);

      // Mixed random traffic on all channels
      for (int i = 0; i < 24; i++) send(4'($urandom_range(0, 15)));
      idle(11);

      // Reset mid-operation: in-flight spikes lost, defaults restored
      send(4'b1111);
      rst_n = 1'b0;
      sb.delete();
      for (int c = 0; c < N_CH; c++) begin dly[c] = 1; wgt[c] = 1; end
      #1;
      check("midrst_spike_out", spike_out, 0);
      check("midrst_psc_out", $signed(psc_out), 0);
      step();
      rst_n = 1'b1;
      step();
      send(4'b1111);
      idle(10);

      check("sb_leftover", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
